matrix_op_controller: RTL and testbench

//  Sequencer for the coprocessor's combinational 5x5 int8 matrix add/sub datapath.
//  - Accepts one command at a time; reads A (and B) row-by-row from single-port sync memory.
//  - Drives the external ALU with packed 200-bit operands; registers the result.
//  - Writes the result rows back to memory, then reports done, overflow and error.

---
 rtl/matrix_op_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_matrix_op_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_controller.sv
// matrix_op_controller
//   Sequencer for a combinational 5x5 int8 matrix add/sub datapath. It accepts
//   one command at a time. It reads A (and B) one row per word from a
//   single-port synchronous memory, drives the external ALU, and registers the
//   result. It then writes C back row by row and reports done / overflow / error.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op                     00 ADD, 01 SUB, 10 NEG (C = 0 - A), 11 illegal
//   cmd_addr_a/_b/_c           base word addresses of A, B, C
//   mem_addr/rd_en/rdata       memory read port (data one cycle after rd_en)
//   mem_wr_en/wdata            memory write port
//   alu_sub, alu_a/b_flat      ALU controls and packed operands
//   alu_c_flat, alu_ovf        ALU result and overflow (combinational)
//   busy, done                 status; done is a one-cycle pulse
//   done_ovf, done_err         completion status, held until next acceptance
//
// Configuration
//   COPROC_OVF_ABORT_EN : when defined, an overflow at EXEC skips the store
//                         phase and reports done_ovf=1, done_err=1.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// LOAD   | one read per cycle (A rows, then B rows unless NEG)
// LWAIT  | capture the last read word
// EXEC   | register ALU result and overflow
// STORE  | write C rows 0..4, one per cycle
// DONE   | done pulse, status valid

module matrix_op_controller #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_c,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [39:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [39:0]       mem_wdata,
  output logic              alu_sub,
  output logic [199:0]      alu_a_flat,
  output logic [199:0]      alu_b_flat,
  input  logic [199:0]      alu_c_flat,
  input  logic              alu_ovf,
  output logic              busy,
  output logic              done,
  output logic              done_ovf,
  output logic              done_err
);

  localparam int ROW_W = 40;
  localparam int ROWS  = 5;
  localparam int MAT_W = 200;

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LWAIT, S_EXEC, S_STORE, S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        row;
  logic              phase_b;
  logic              neg_r;
  logic [ADDR_W-1:0] addr_b_r;
  logic [ADDR_W-1:0] addr_c_r;
  logic              cap_en;
  logic [2:0]        cap_row;
  logic              cap_b;
  logic [MAT_W-1:0]  op_a;
  logic [MAT_W-1:0]  op_b;
  logic [MAT_W-1:0]  result;
  logic              ovf_r;

  // NEG loads A into op_b and leaves op_a cleared, so the ALU computes 0 - A
  // straight from the operand registers.
  assign alu_a_flat = op_a;
  assign alu_b_flat = op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      phase_b   <= 1'b0;
      neg_r     <= 1'b0;
      addr_b_r  <= '0;
      addr_c_r  <= '0;
      cap_en    <= 1'b0;
      cap_row   <= '0;
      cap_b     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      ovf_r     <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
      alu_sub   <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      done_ovf  <= 1'b0;
      done_err  <= 1'b0;
    end else begin
      done <= 1'b0;

      // Read data arrives one cycle after its strobe; the destination row
      // travels alongside in cap_row / cap_b.
      if (cap_en) begin
        if (cap_b) op_b[ROW_W*int'(cap_row) +: ROW_W] <= mem_rdata;
        else       op_a[ROW_W*int'(cap_row) +: ROW_W] <= mem_rdata;
      end
      cap_en  <= mem_rd_en;
      cap_row <= row;
      cap_b   <= phase_b | neg_r;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_b_r  <= cmd_addr_b;
            addr_c_r  <= cmd_addr_c;
            neg_r     <= (cmd_op == OP_NEG);
            alu_sub   <= (cmd_op != OP_ADD);
            op_a      <= '0;
            op_b      <= '0;
            row       <= '0;
            phase_b   <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            done_ovf  <= 1'b0;
            done_err  <= 1'b0;
            if (cmd_op == OP_ILL) begin
              state    <= S_DONE;
              done     <= 1'b1;
              done_err <= 1'b1;
            end else begin
              state     <= S_LOAD;
              mem_rd_en <= 1'b1;
              mem_addr  <= cmd_addr_a;
            end
          end
        end

        S_LOAD: begin
          if (row == LAST_ROW) begin
            if (!phase_b && !neg_r) begin
              phase_b  <= 1'b1;
              row      <= '0;
              mem_addr <= addr_b_r;
            end else begin
              mem_rd_en <= 1'b0;
              state     <= S_LWAIT;
            end
          end else begin
            row      <= row + 3'd1;
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end

        S_LWAIT: state <= S_EXEC;

        S_EXEC: begin
          result <= alu_c_flat;
          ovf_r  <= alu_ovf;
`ifdef COPROC_OVF_ABORT_EN
          if (alu_ovf) begin
            state    <= S_DONE;
            done     <= 1'b1;
            done_ovf <= 1'b1;
            done_err <= 1'b1;
          end else
`endif
          begin
            state     <= S_STORE;
            mem_wr_en <= 1'b1;
            mem_addr  <= addr_c_r;
            mem_wdata <= alu_c_flat[ROW_W-1:0];
            row       <= '0;
          end
        end

        S_STORE: begin
          if (row == LAST_ROW) begin
            mem_wr_en <= 1'b0;
            state     <= S_DONE;
            done      <= 1'b1;
            done_ovf  <= ovf_r;
          end else begin
            row       <= row + 3'd1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= result[ROW_W*(int'(row)+1) +: ROW_W];
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_op_controller.sv
// Directed bench for matrix_op_controller: memory model, int8 ALU model,
// hand-computed expectations for SUB, ADD with overflow, NEG with address
// wrap, illegal op, back-to-back command and reset during STORE.
module tb_matrix_op_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [7:0]   cmd_addr_a, cmd_addr_b, cmd_addr_c;
  logic [7:0]   mem_addr;
  logic         mem_rd_en;
  logic [39:0]  mem_rdata;
  logic         mem_wr_en;
  logic [39:0]  mem_wdata;
  logic         alu_sub;
  logic [199:0] alu_a_flat, alu_b_flat, alu_c_flat;
  logic         alu_ovf;
  logic         busy, done, done_ovf, done_err;

  matrix_op_controller #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_c(cmd_addr_c),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .alu_sub(alu_sub), .alu_a_flat(alu_a_flat), .alu_b_flat(alu_b_flat),
    .alu_c_flat(alu_c_flat), .alu_ovf(alu_ovf),
    .busy(busy), .done(done), .done_ovf(done_ovf), .done_err(done_err)
  );

  always #5 clk = ~clk;

  // int8 element-wise ALU
  logic signed [8:0] alu_s;
  always_comb begin
    alu_c_flat = '0;
    alu_ovf    = 1'b0;
    alu_s      = '0;
    for (int i = 0; i < 25; i++) begin
      if (alu_sub)
        alu_s = {alu_a_flat[i*8+7], alu_a_flat[i*8 +: 8]} - {alu_b_flat[i*8+7], alu_b_flat[i*8 +: 8]};
      else
        alu_s = {alu_a_flat[i*8+7], alu_a_flat[i*8 +: 8]} + {alu_b_flat[i*8+7], alu_b_flat[i*8 +: 8]};
      alu_c_flat[i*8 +: 8] = alu_s[7:0];
      if (alu_s[8] != alu_s[7]) alu_ovf = 1'b1;
    end
  end

  // memory model with strobe logging
  logic [39:0] mem [256];
  logic [7:0]  rd_q [$];
  logic [7:0]  wr_q [$];
  int rd_cnt, wr_cnt, both_cnt;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt++;
      rd_q.push_back(mem_addr);
    end
    if (mem_wr_en) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt++;
      wr_q.push_back(mem_addr);
    end
    if (mem_rd_en && mem_wr_en) both_cnt++;
  end

  int n_vec = 0;
  int n_err = 0;
  int lat;
  logic ovf_at_done, err_at_done, busy_c1, ready_c1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    rd_q.delete(); wr_q.delete();
  endtask

  // Issues one command and returns the cycle (1 = first cycle after accept)
  // in which done was seen, or 0 if it never came within the budget.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, output int latency);
    clear_logs();
    latency = 0;
    @(negedge clk);
    cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_c = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin busy_c1 = busy; ready_c1 = cmd_ready; end
      if (done) begin
        latency = cyc;
        ovf_at_done = done_ovf;
        err_at_done = done_err;
        break;
      end
    end
    @(negedge clk);
  endtask

  int done1, done2, ready_cyc;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_addr_a = '0; cmd_addr_b = '0; cmd_addr_c = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #23;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_done_ovf", done_ovf, 0);
    check("rst_done_err", done_err, 0);
    check("rst_alu_a", alu_a_flat[63:0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: SUB 10-3 on every element
    for (int i = 0; i < 5; i++) begin
      mem[i] = 40'h0A0A0A0A0A; mem[5+i] = 40'h0303030303; mem[10+i] = 40'h5555555555;
    end
    run_cmd(2'b01, 8'd0, 8'd5, 8'd10, lat);
    check("sub_latency", lat, 18);
    check("sub_busy_c1", busy_c1, 1);
    check("sub_ready_c1", ready_c1, 0);
    check("sub_reads", rd_cnt, 10);
    check("sub_writes", wr_cnt, 5);
    check("sub_both", both_cnt, 0);
    check("sub_rd_first", rd_q[0], 8'd0);
    check("sub_rd_b0", rd_q[5], 8'd5);
    check("sub_rd_last", rd_q[9], 8'd9);
    for (int i = 0; i < 5; i++) check($sformatf("sub_c_row%0d", i), mem[10+i], 40'h0707070707);
    check("sub_ovf", ovf_at_done, 0);
    check("sub_err", err_at_done, 0);
    check("sub_idle_ready", cmd_ready, 1);

    // 2: ADD 100+100 in element (0,0) only
    mem[20] = 40'h64; mem[30] = 40'h64;
    for (int i = 1; i < 5; i++) begin mem[20+i] = '0; mem[30+i] = '0; end
    for (int i = 0; i < 5; i++) mem[40+i] = 40'hAAAAAAAAAA;
    run_cmd(2'b00, 8'd20, 8'd30, 8'd40, lat);
    check("add_ovf", ovf_at_done, 1);
`ifdef COPROC_OVF_ABORT_EN
    check("add_latency", lat, 13);
    check("add_writes", wr_cnt, 0);
    check("add_err", err_at_done, 1);
    check("add_c_row0", mem[40], 40'hAAAAAAAAAA);
`else
    check("add_latency", lat, 18);
    check("add_writes", wr_cnt, 5);
    check("add_err", err_at_done, 0);
    check("add_c_row0", mem[40], 40'h00000000C8);
    check("add_c_row1", mem[41], 40'h0);
    check("add_c_row4", mem[44], 40'h0);
`endif
    repeat (3) @(negedge clk);
    check("add_ovf_held", done_ovf, 1);

    // 3: NEG with C base wrapping through 0
    for (int i = 0; i < 5; i++) mem[50+i] = 40'h0101010101;
    run_cmd(2'b10, 8'd50, 8'h63, 8'hFE, lat);
    check("neg_latency", lat, 13);
    check("neg_reads", rd_cnt, 5);
    check("neg_rd_last", rd_q[4], 8'd54);
    check("neg_writes", wr_cnt, 5);
    check("neg_wr0", wr_q[0], 8'hFE);
    check("neg_wr1", wr_q[1], 8'hFF);
    check("neg_wr2", wr_q[2], 8'h00);
    check("neg_wr4", wr_q[4], 8'h02);
    check("neg_c_fe", mem[8'hFE], 40'hFFFFFFFFFF);
    check("neg_c_00", mem[0], 40'hFFFFFFFFFF);
    check("neg_c_02", mem[2], 40'hFFFFFFFFFF);
    check("neg_ovf", ovf_at_done, 0);
    check("neg_err", err_at_done, 0);

    // 4: illegal op
    run_cmd(2'b11, 8'd0, 8'd5, 8'd10, lat);
    check("ill_latency", lat, 1);
    check("ill_err", err_at_done, 1);
    check("ill_ovf", ovf_at_done, 0);
    check("ill_reads", rd_cnt, 0);
    check("ill_writes", wr_cnt, 0);

    // 5: cmd_valid held through a busy command; new fields take effect only
    //    when the second command is accepted after done
    for (int i = 0; i < 5; i++) begin
      mem[i] = 40'h0A0A0A0A0A; mem[60+i] = '0; mem[70+i] = '0;
    end
    clear_logs();
    done1 = 0; done2 = 0; ready_cyc = 0;
    @(negedge clk);
    cmd_op = 2'b01; cmd_addr_a = 8'd0; cmd_addr_b = 8'd5; cmd_addr_c = 8'd60;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_op = 2'b00; cmd_addr_c = 8'd70;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (done1 == 0) done1 = cyc;
        else if (done2 == 0) done2 = cyc;
      end
      if (cmd_ready && ready_cyc == 0) ready_cyc = cyc;
      if (ready_cyc != 0 && cyc == ready_cyc + 1) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    check("b2b_done1", done1, 18);
    check("b2b_ready", ready_cyc, 19);
    check("b2b_done2", done2, 37);
    check("b2b_writes", wr_cnt, 10);
    check("b2b_first_c", mem[60], 40'h0707070707);
    check("b2b_first_c4", mem[64], 40'h0707070707);
    check("b2b_second_c", mem[70], 40'h0D0D0D0D0D);
    check("b2b_second_c4", mem[74], 40'h0D0D0D0D0D);

    // 6: reset while writing C row 2
    for (int i = 0; i < 5; i++) begin
      mem[80+i] = 40'h0A0A0A0A0A; mem[85+i] = 40'h0303030303; mem[90+i] = 40'h1111111111;
    end
    clear_logs();
    @(negedge clk);
    cmd_op = 2'b01; cmd_addr_a = 8'd80; cmd_addr_b = 8'd85; cmd_addr_c = 8'd90;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("rst6_pre_wr_en", mem_wr_en, 1);
    check("rst6_pre_addr", mem_addr, 8'd92);
    rst_n = 1'b0;
    #1;
    check("rst6_wr_en", mem_wr_en, 0);
    check("rst6_busy", busy, 0);
    check("rst6_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("rst6_writes", wr_cnt, 2);
    check("rst6_row0", mem[90], 40'h0707070707);
    check("rst6_row1", mem[91], 40'h0707070707);
    check("rst6_row2", mem[92], 40'h1111111111);
    check("rst6_row4", mem[94], 40'h1111111111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
